// File: rtl/dmem_pkg.sv
// +----------------------------------------------------------------------+
// | dmem_pkg: shared types and helpers for the data-memory responder     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package dmem_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int word_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // A request is rejected when it is not word aligned or its word index falls past the array.
    function automatic logic access_error(input logic [31:0] addr, input logic [31:0] depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// +----------------------------------------------------------------------+
// | dmem_array: single-port word array, synchronous write and read       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Contents are deliberately not reset; rdata only updates on an enabled read.
    always_ff @(posedge clk_i) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// +----------------------------------------------------------------------+
// | data_mem_responder: fixed-latency load/store responder for MEM stage |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int AW = word_addr_w(DEPTH_WORDS);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             we_q;
    logic [31:0]      rdata_hold;

    logic             access_now;
    logic             access_err;
    logic             arr_en;
    logic [AW-1:0]    arr_idx;
    logic [31:0]      arr_rdata;

    assign access_now = (state == BUSY) && (cnt == '0);
    assign access_err = access_error(addr_q, 32'(DEPTH_WORDS));
    assign arr_en     = access_now && !access_err;
    assign arr_idx    = addr_q[AW+1:2];

    assign stall_o = (req_i && (state != DONE)) || (state == BUSY);

    dmem_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_array (
        .clk_i (clk_i),
        .en    (arr_en),
        .we    (we_q),
        .idx   (arr_idx),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (req_i) begin
                    state_next = BUSY;
                    cnt_next   = CNT_W'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if ((state == IDLE) && req_i) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            we_q    <= we_i;
        end
    end

    // ack/err are set by the access edge and naturally drop one cycle later as DONE exits.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
        end else begin
            ack_o <= access_now;
            err_o <= access_now && access_err;
        end
    end

    // The array's read register already holds the load result in DONE, so rdata_o is a
    // flop-sourced select; rdata_hold retires that value when DONE exits.
    always_comb begin
        rdata_o = rdata_hold;
        if (state == DONE) begin
            if (err_o) begin
                rdata_o = '0;
            end else if (!we_q) begin
                rdata_o = arr_rdata;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_hold <= '0;
        end else if (state == DONE) begin
            rdata_hold <= rdata_o;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// Randomised self-checking bench: two responder builds (LATENCY 4 and 1) against a
// transaction-level memory model.
`default_nettype none

module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 4;

    logic        clk;
    logic        rst_n;

    logic        a_req, a_we, a_ack, a_err, a_stall;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_req, b_we, b_ack, b_err, b_stall;
    logic [31:0] b_addr, b_wdata, b_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] model_mem [2][DEPTH];
    logic [31:0] model_rd  [2];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut_a (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .req_i   (a_req),
        .we_i    (a_we),
        .addr_i  (a_addr),
        .wdata_i (a_wdata),
        .rdata_o (a_rdata),
        .ack_o   (a_ack),
        .err_o   (a_err),
        .stall_o (a_stall)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_b (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .req_i   (b_req),
        .we_i    (b_we),
        .addr_i  (b_addr),
        .wdata_i (b_wdata),
        .rdata_o (b_rdata),
        .ack_o   (b_ack),
        .err_o   (b_err),
        .stall_o (b_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request (called just after a rising edge), waits for its ack and
    // compares timing, error flag and read data with the model.
    task automatic transact(input int sel, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input string tag, output int ack_cyc);
        int   lat;
        int   n;
        int   stalls;
        bit   got_ack;
        logic exp_err;
        logic ack_s, err_s, stall_s;
        logic [31:0] rd_s;
        lat     = (sel == 1) ? 1 : LAT;
        n       = 0;
        stalls  = 0;
        got_ack = 0;
        ack_cyc = -1;
        exp_err = ((addr % 4) != 0) || ((addr / 4) >= DEPTH);
        if (sel == 1) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
        end
        rd_s = '0; err_s = 1'b0; stall_s = 1'b0;
        while (!got_ack && n < 40) begin
            @(negedge clk);
            n++;
            ack_s   = (sel == 1) ? b_ack   : a_ack;
            err_s   = (sel == 1) ? b_err   : a_err;
            stall_s = (sel == 1) ? b_stall : a_stall;
            rd_s    = (sel == 1) ? b_rdata : a_rdata;
            if (ack_s) begin
                got_ack = 1;
                ack_cyc = cyc;
            end else if (stall_s) begin
                stalls++;
            end
        end
        if (!got_ack) begin
            check_value({tag, "_ack_timeout"}, 32'd0, 32'd1);
        end else begin
            if (exp_err) begin
                model_rd[sel] = '0;
            end else if (we) begin
                model_mem[sel][addr / 4] = wdata;
            end else begin
                model_rd[sel] = model_mem[sel][addr / 4];
            end
            check_value({tag, "_ack_cycle"}, 32'(n - 1), 32'(lat + 1));
            check_value({tag, "_stall_cycles"}, 32'(stalls), 32'(lat + 1));
            check_value({tag, "_stall_in_ack"}, {31'd0, stall_s}, 32'd0);
            check_value({tag, "_err"}, {31'd0, err_s}, {31'd0, exp_err});
            check_value({tag, "_rdata"}, rd_s, model_rd[sel]);
        end
        @(posedge clk);
        #1;
        if (sel == 1) b_req = 1'b0; else a_req = 1'b0;
    endtask

    initial begin
        int          c0;
        int          c1;
        int          acks;
        int          k;
        logic        rwe;
        logic [31:0] raddr;

        rst_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        model_rd[0] = '0;
        model_rd[1] = '0;

        repeat (2) @(negedge clk);
        check_value("rst_ack", {31'd0, a_ack}, 32'd0);
        check_value("rst_err", {31'd0, a_err}, 32'd0);
        check_value("rst_rdata", a_rdata, 32'd0);
        check_value("rst_stall", {31'd0, a_stall}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_value("idle_stall", {31'd0, a_stall | b_stall}, 32'd0);
            check_value("idle_ack", {31'd0, a_ack | b_ack}, 32'd0);
        end
        @(posedge clk); #1;

        transact(0, 1'b1, 32'h10, 32'hDEADBEEF, "store_10", c0);
        transact(0, 1'b0, 32'h10, 32'h0, "load_10", c0);
        @(negedge clk);
        check_value("rdata_hold", a_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        for (int w = 0; w < 16; w++) begin
            if (w != 4) transact(0, 1'b1, 32'(w * 4), $urandom, "preload", c0);
        end

        transact(0, 1'b0, 32'h10, 32'h0, "b2b_first", c0);
        transact(0, 1'b0, 32'h14, 32'h0, "b2b_second", c1);
        check_value("b2b_gap", 32'(c1 - c0), 32'(LAT + 2));

        transact(0, 1'b0, 32'h13, 32'h0, "misaligned", c0);
        transact(0, 1'b1, 32'h400, 32'h12345678, "store_oob", c0);
        transact(0, 1'b0, 32'h0, 32'h0, "load_0_after_oob", c0);

        // Abort a store in its second busy cycle.
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'h55AA55AA;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("async_rst_ack", {31'd0, a_ack}, 32'd0);
        check_value("async_rst_err", {31'd0, a_err}, 32'd0);
        check_value("async_rst_rdata", a_rdata, 32'd0);
        a_req = 1'b0;
        #1;
        check_value("async_rst_stall", {31'd0, a_stall}, 32'd0);
        model_rd[0] = '0;
        model_rd[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a_ack) acks++;
        end
        check_value("no_ack_after_rst", 32'(acks), 32'd0);
        @(posedge clk); #1;
        transact(0, 1'b0, 32'h20, 32'h0, "load_20_after_abort", c0);

        for (int t = 0; t < 40; t++) begin
            k   = int'($urandom_range(0, 9));
            rwe = 1'($urandom_range(0, 1));
            if (k == 0) begin
                raddr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            end else if (k == 1) begin
                raddr = 32'h400 + 32'($urandom_range(0, 1000) * 4);
            end else begin
                raddr = 32'($urandom_range(0, 15) * 4);
            end
            transact(0, rwe, raddr, $urandom, "rand", c0);
        end

        transact(1, 1'b1, 32'h0C, 32'hA5A5_0F0F, "lat1_store", c0);
        transact(1, 1'b0, 32'h0C, 32'h0, "lat1_load", c0);
        transact(1, 1'b0, 32'h0D, 32'h0, "lat1_misaligned", c0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Multi-cycle data-memory responder serving the pipelined CPU's MEM-stage load/store requests.
- Models a fixed access latency.
- Asserts stall_o back to the CPU so the hazard/stall logic freezes PC, IFID, IDEX and EXMEM while the access is in flight.
- Returns read data and a one-cycle ack_o on completion.
- Replaces the single-cycle Data_Memory and is the responder end of the CPU's memory-request interface.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the backing array (power of two).
LATENCY, 4, busy cycles between request capture and completion (legal range 1..15).

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  reset; asynchronous, active-low (0 = reset)
req_i  in  1  access request from the CPU MEM stage (MemRead or MemWrite); held stable by the CPU while stall_o=1
we_i  in  1  1 = store, 0 = load; sampled with req_i
addr_i  in  32  byte address (ALU result)
wdata_i  in  32  store data (RT value)
rdata_o  out  32  load data; valid while ack_o=1
ack_o  out  1  one-cycle completion pulse
err_o  out  1  completion with error (misaligned or out of range); coincident with ack_o
stall_o  out  1  pipeline freeze request to CPU

Behaviour:
- FSM states are IDLE, BUSY and DONE. Registered outputs: rdata_o, ack_o, err_o. State registers: cnt, state.
- Reset (rst_i=0, async): state=IDLE, cnt=0, rdata_o=0, ack_o=0, err_o=0, captured addr/data/we=0. Array contents are not reset.
- stall_o is combinational: stall_o = req_i & (state != DONE) | (state == BUSY).
- IDLE:
  - If req_i=1, capture addr_i/wdata_i/we_i, load cnt=LATENCY-1 and go to BUSY.
  - Otherwise remain in IDLE.
  - stall_o=1 in the capture cycle.
- BUSY:
  - While cnt!=0, decrement cnt.
  - When cnt==0, perform the access at this edge and go to DONE.
  - The access is skipped if the captured address has addr[1:0]!=0 or word index >= DEPTH_WORDS.
- Access rules:
  - Store: array[addr[..:2]] <= wdata; rdata_o unchanged.
  - Load: rdata_o <= array[addr[..:2]].
  - Error: err_o<=1, rdata_o<=0, no write.
- DONE: ack_o=1 for exactly one cycle, stall_o=0, the CPU pipeline advances at this edge, and the next state is always IDLE. ack_o/err_o clear on leaving DONE.
- Latency: request captured at edge E0; ack_o high in the cycle after edge E0+LATENCY. Total stall is LATENCY+1 cycles; ack arrives in cycle LATENCY+1.
- Back-to-back: a new request presented in the cycle after DONE is accepted from IDLE. There is no request merging.
- rdata_o holds the last successful load value until the next load completes or reset.
- req_i deasserting while BUSY is a protocol violation. The transaction still completes with the captured values, including the write.
- Reset mid-BUSY aborts immediately. No write occurs, and no ack is produced after reset release.
- Simultaneous req_i during DONE is ignored that cycle and re-sampled in IDLE.

Decomposition:
- Shared package dmem_pkg holds:
  - state enum {IDLE, BUSY, DONE}
  - CNT_W=4
  - WORD_ADDR_W=$clog2(DEPTH_WORDS) helper
  - error-check function (alignment/range)
- Sub-module dmem_array: synchronous-write, synchronous-read single-port word array (clk_i, en, we, idx, wdata, rdata). It is instantiated once. FSM, counter and capture registers stay in data_mem_responder.

Test Plan:
- Reset then store: rst_i=0→1; req_i=1, we_i=1, addr_i=0x10, wdata_i=0xDEADBEEF held. The response must show:
  - stall_o=1 for 5 cycles (LATENCY=4)
  - ack_o pulse in cycle 5
  - err_o=0
- Load after store: req_i=1, we_i=0, addr_i=0x10 → ack_o in cycle 5 with rdata_o=0xDEADBEEF, stall_o=0 in the ack cycle.
- Back-to-back: load 0x10, then a load of 0x14 presented in the cycle after ack. The response must show:
  - second ack 6 cycles after the first
  - rdata_o=0x00000000-initialised/preloaded value
  - no lost request
- Misaligned/out-of-range: addr_i=0x13 → ack_o=1 & err_o=1, rdata_o=0. Store to addr_i=0x400 (DEPTH_WORDS=256) → err_o=1, and a subsequent load of 0x0 is unchanged.
- Reset mid-access: store 0x55AA55AA to 0x20, assert rst_i=0 in the second BUSY cycle. The response must show:
  - outputs 0 asynchronously
  - no ack after release
  - a later load of 0x20 returns the pre-existing value
- LATENCY=1 build: load completes with stall_o=1 for 2 cycles and ack in cycle 2. Idle cycles with req_i=0 leave stall_o=0 and ack_o=0.
